// File: rtl/gamepad_buttons.sv
// gamepad_buttons
//   Button input peripheral for the PicoSoC iomem bus. Each active-low button
//   goes through a two-flop synchroniser and a per-button debounce counter.
//   Press and release edges of the debounced state latch into sticky
//   write-1-to-clear registers. Enabled events raise a registered level
//   interrupt.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   iomem_valid  bus request (already address-decoded by the top level)
//   iomem_ready  single-cycle acknowledge, one wait state
//   iomem_wstrb  byte write strobes, 4'b0000 = read
//   iomem_addr   byte address, only [3:2] decoded
//   iomem_wdata  write data
//   iomem_rdata  registered read data, valid while iomem_ready = 1
//   buttons_n    raw asynchronous buttons, 0 = pressed
//   irq          level interrupt
//
// Register map (addr[3:2])
//   0 STATE    RO   debounced state, 1 = pressed
//   1 PRESSED  W1C  sticky press events
//   2 RELEASED W1C  sticky release events
//   3 IRQ_EN   RW   [15:0] press enables, [31:16] release enables
module gamepad_buttons #(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 16000,
  parameter int CNT_WIDTH       = 14
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   iomem_valid,
  output logic                   iomem_ready,
  input  logic [3:0]             iomem_wstrb,
  input  logic [31:0]            iomem_addr,
  input  logic [31:0]            iomem_wdata,
  output logic [31:0]            iomem_rdata,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  output logic                   irq
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    REG_STATE    = 2'd0,
    REG_PRESSED  = 2'd1,
    REG_RELEASED = 2'd2,
    REG_IRQ_EN   = 2'd3
  } reg_idx_e;

  // Synchroniser and debounce state
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] sample;
  logic [NUM_BUTTONS-1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] rise, fall;

  // Event and enable registers
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] released_q, released_d;
  logic [NUM_BUTTONS-1:0] press_en_q, press_en_d;
  logic [NUM_BUTTONS-1:0] rel_en_q, rel_en_d;

  // Bus side
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        req, wr, rd;
  reg_idx_e    reg_sel;
  logic [15:0] lo_mask, hi_mask;
  logic [NUM_BUTTONS-1:0] lo_wbits, hi_wbits;
  logic [31:0] rd_word;
  logic        unused;

  assign sample = ~sync2_q;

  // Debounce: the counter only runs while the synchronised input disagrees
  // with the accepted state, so any return to agreement restarts the wait.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sample[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = sample[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign rise = state_d & ~state_q;
  assign fall = ~state_d & state_q;

  // A request is taken only while ready is low, which yields one wait state
  // and guarantees ready never stays high for two cycles.
  assign req     = iomem_valid & ~ready_q;
  assign wr      = req & (|iomem_wstrb);
  assign rd      = req & ~(|iomem_wstrb);
  assign reg_sel = reg_idx_e'(iomem_addr[3:2]);

  assign lo_mask  = {{8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign hi_mask  = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}};
  assign lo_wbits = iomem_wdata[NUM_BUTTONS-1:0]  & lo_mask[NUM_BUTTONS-1:0];
  assign hi_wbits = iomem_wdata[16 +: NUM_BUTTONS] & hi_mask[NUM_BUTTONS-1:0];

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STATE:    rd_word[NUM_BUTTONS-1:0] = state_q;
      REG_PRESSED:  rd_word[NUM_BUTTONS-1:0] = pressed_q;
      REG_RELEASED: rd_word[NUM_BUTTONS-1:0] = released_q;
      REG_IRQ_EN: begin
        rd_word[NUM_BUTTONS-1:0]   = press_en_q;
        rd_word[16 +: NUM_BUTTONS] = rel_en_q;
      end
      default:      rd_word = '0;
    endcase
  end

  always_comb begin
    ready_d    = req;
    rdata_d    = rd ? rd_word : rdata_q;
    pressed_d  = pressed_q;
    released_d = released_q;
    press_en_d = press_en_q;
    rel_en_d   = rel_en_q;

    if (wr && reg_sel == REG_PRESSED)  pressed_d  = pressed_q  & ~lo_wbits;
    if (wr && reg_sel == REG_RELEASED) released_d = released_q & ~lo_wbits;
    if (wr && reg_sel == REG_IRQ_EN) begin
      press_en_d = (press_en_q & ~lo_mask[NUM_BUTTONS-1:0]) | lo_wbits;
      rel_en_d   = (rel_en_q   & ~hi_mask[NUM_BUTTONS-1:0]) | hi_wbits;
    end

    // Events are OR-ed in after the clear so a same-edge set wins.
    pressed_d  = pressed_d  | rise;
    released_d = released_d | fall;

    irq_d = (|(pressed_q & press_en_q)) | (|(released_q & rel_en_q));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      press_en_q <= '0;
      rel_en_q   <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset like any other state to keep the debounce timing deterministic.
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= buttons_n;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      press_en_q <= press_en_d;
      rel_en_q   <= rel_en_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

  // Address bits outside [3:2] and write data outside the implemented
  // fields are intentionally ignored.
  assign unused = ^{iomem_addr[31:4], iomem_addr[1:0], iomem_wdata, lo_mask, hi_mask};

endmodule

// File: tb/tb_gamepad_buttons.sv
module tb_gamepad_buttons;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [NB-1:0] buttons_n;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  logic irq_at_rdy, irq_after;

  always #5 clk = ~clk;

  gamepad_buttons #(
    .NUM_BUTTONS(NB),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .buttons_n(buttons_n),
    .irq(irq)
  );

  typedef struct {
    logic [1:0]  idx;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [3:0] strb, input logic [31:0] data);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0000 | {28'h0, idx, 2'b00};
    iomem_wstrb = strb;
    iomem_wdata = data;
    tick();
    check("write ready", {31'h0, iomem_ready}, 32'h1);
    irq_at_rdy  = irq;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
    check("write ready drop", {31'h0, iomem_ready}, 32'h0);
    irq_after = irq;
  endtask

  // Valid is held across the second edge to show ready drops regardless.
  task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0000 | {28'h0, idx, 2'b00};
    iomem_wstrb = 4'h0;
    tick();
    check("read ready", {31'h0, iomem_ready}, 32'h1);
    data = iomem_rdata;
    tick();
    check("read ready drop", {31'h0, iomem_ready}, 32'h0);
    iomem_valid = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [1:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(idx, d);
    check(name, d, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd3, 4'b0100, 32'hFFFF_FFFF, 32'h00FF_0000};
    vecs[1] = '{2'd3, 4'b0001, 32'h0000_00A5, 32'h00FF_00A5};
    vecs[2] = '{2'd3, 4'b1111, 32'h1234_5678, 32'h0034_0078};
    vecs[3] = '{2'd3, 4'b0010, 32'hFFFF_FFFF, 32'h0034_0078};
    vecs[4] = '{2'd3, 4'b1000, 32'hFFFF_FFFF, 32'h0034_0078};
    vecs[5] = '{2'd0, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{2'd1, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{2'd2, 4'b1111, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8] = '{2'd3, 4'b1111, 32'h0000_0000, 32'h0000_0000};

    resetn      = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0600_0000;
    iomem_wdata = 32'h0;
    buttons_n   = '1;
    #2;
    check("reset ready", {31'h0, iomem_ready}, 32'h0);
    check("reset rdata", iomem_rdata, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Reset values of every register
    check_rd("reset STATE", 2'd0, 32'h0);
    check_rd("reset PRESSED", 2'd1, 32'h0);
    check_rd("reset RELEASED", 2'd2, 32'h0);
    check_rd("reset IRQ_EN", 2'd3, 32'h0);

    // Table: write with strobes, read back
    for (int i = 0; i < 9; i++) begin
      logic [31:0] d;
      bus_write(vecs[i].idx, vecs[i].wstrb, vecs[i].wdata);
      bus_read(vecs[i].idx, d);
      check($sformatf("vec%0d readback", i), d, vecs[i].exp);
    end
    check("irq after table", {31'h0, irq}, 32'h0);

    // Glitch of 3 cycles on button 0 is one cycle short of acceptance
    buttons_n[0] = 1'b0;
    repeat (3) tick();
    buttons_n[0] = 1'b1;
    repeat (8) tick();
    check_rd("glitch STATE", 2'd0, 32'h0);
    check_rd("glitch PRESSED", 2'd1, 32'h0);

    // Press button 3 with its press interrupt enabled
    bus_write(2'd3, 4'b1111, 32'h0000_0008);
    check("irq before press", {31'h0, irq}, 32'h0);
    buttons_n[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("irq early edge %0d", k), {31'h0, irq}, 32'h0);
    end
    tick();
    check("irq after press", {31'h0, irq}, 32'h1);
    check_rd("press STATE", 2'd0, 32'h08);
    check_rd("press PRESSED", 2'd1, 32'h08);
    check_rd("press RELEASED", 2'd2, 32'h00);

    // W1C clear: irq still high on the ready edge, low one edge later
    bus_write(2'd1, 4'b1111, 32'h0000_0008);
    check("irq at clear ready", {31'h0, irq_at_rdy}, 32'h1);
    check("irq after clear", {31'h0, irq_after}, 32'h0);
    check_rd("clear PRESSED", 2'd1, 32'h00);
    check_rd("clear RELEASED", 2'd2, 32'h00);

    // Collision: W1C of PRESSED[5] on the edge where state[5] rises
    buttons_n[5] = 1'b0;
    repeat (5) tick();
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_0004;
    iomem_wstrb = 4'b1111;
    iomem_wdata = 32'h0000_0020;
    tick();
    check("collide ready", {31'h0, iomem_ready}, 32'h1);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
    check_rd("collide PRESSED", 2'd1, 32'h20);
    check_rd("collide STATE", 2'd0, 32'h28);
    check("collide irq", {31'h0, irq}, 32'h0);

    // Release interrupt on button 5, byte-lane-qualified W1C
    bus_write(2'd3, 4'b1111, 32'h0020_0000);
    buttons_n = '1;
    repeat (8) tick();
    check("irq on release", {31'h0, irq}, 32'h1);
    check_rd("release STATE", 2'd0, 32'h00);
    check_rd("release RELEASED", 2'd2, 32'h28);
    check_rd("release PRESSED", 2'd1, 32'h20);
    bus_write(2'd2, 4'b0010, 32'h0000_0020);
    check_rd("wrong lane RELEASED", 2'd2, 32'h28);
    check("irq wrong lane", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 4'b0001, 32'h0000_0020);
    check_rd("lane clear RELEASED", 2'd2, 32'h08);
    check("irq lane clear", {31'h0, irq}, 32'h0);

    // Byte strobe write, then async reset while ready is high
    bus_write(2'd3, 4'b0100, 32'hFFFF_FFFF);
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_000C;
    iomem_wstrb = 4'h0;
    tick();
    check("pre-reset ready", {31'h0, iomem_ready}, 32'h1);
    check("pre-reset rdata", iomem_rdata, 32'h00FF_0000);
    #1 resetn = 1'b0;
    #1;
    check("reset drops ready", {31'h0, iomem_ready}, 32'h0);
    check("reset clears rdata", iomem_rdata, 32'h0);
    iomem_valid = 1'b0;
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_rd("post-reset IRQ_EN", 2'd3, 32'h0);

    // Pending write discarded by reset before its edge
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0600_000C;
    iomem_wstrb = 4'b1111;
    iomem_wdata = 32'hFFFF_FFFF;
    #2 resetn = 1'b0;
    tick();
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check_rd("discarded write IRQ_EN", 2'd3, 32'h0);
    check("final irq", {31'h0, irq}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gamepad_buttons.md
# gamepad_buttons

Memory-mapped button input peripheral on the PicoSoC `iomem` bus, decoded at `0x06xx_xxxx`. It synchronises and debounces active-low push-button inputs and latches sticky press/release events. It returns read data with its own `iomem_ready`, and raises a level interrupt wired to `irq_5`. In the top level, `iomem_rdata` and `iomem_ready` are muxed from this block whenever `iomem_addr[31:24] == 8'h06`.

## Interface

Parameters:
- `NUM_BUTTONS`, 8: number of button inputs, 1..16.
- `DEBOUNCE_CYCLES`, 16000: cycles an input must remain stable before it is accepted (1 ms at 16 MHz). Minimum 2.
- `CNT_WIDTH`, 14: debounce counter width. Must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk` in 1: system clock, 16 MHz.
- `resetn` in 1: one clock; reset is asynchronous and active-low.
- `iomem_valid` in 1: bus request, already qualified by the top-level address decode.
- `iomem_ready` out 1: single-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; `0000` means read.
- `iomem_addr` in 32: only `[3:2]` is decoded.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: registered read data, valid while `iomem_ready` = 1.
- `buttons_n` in `NUM_BUTTONS`: raw asynchronous buttons, 0 = pressed.
- `irq` out 1: level interrupt.

## Operation

Input path:
- Each bit passes through a 2-flop synchroniser; the flops reset to 1 (released).
- The synchronised value is inverted to give `sample` (1 = pressed).

Debounce, per button (counter `cnt[i]`, debounced bit `state[i]`):
- If `sample[i] == state[i]`: `cnt[i]` ← 0.
- Else, if `cnt[i] == DEBOUNCE_CYCLES-1`: `state[i]` ← `sample[i]` and `cnt[i]` ← 0.
- Else: `cnt[i]` ← `cnt[i]` + 1.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `state`.

Events:
- A rising edge of `state[i]` sets `pressed[i]`; a falling edge sets `released[i]`.
- Both bits are sticky and cleared by write-1-to-clear (W1C).
- If an event and a W1C clear of the same bit land on the same edge, the set wins.

Register map (`addr[3:2]`); unused high bits read 0:
- 0 `STATE` (RO): `state`. Writes are ignored.
- 1 `PRESSED` (W1C).
- 2 `RELEASED` (W1C).
- 3 `IRQ_EN` (RW): bits `[15:0]` enable press interrupts, bits `[31:16]` enable release interrupts. Only `NUM_BUTTONS` bits of each half are implemented.

Writes honour `iomem_wstrb` per byte lane.

Interrupt:
- `irq` = `|(pressed & IRQ_EN[15:0]) | |(released & IRQ_EN[31:16])`, registered.

## Timing

Reset (asynchronous) values:
- Outputs: `iomem_ready`=0, `iomem_rdata`=0, `irq`=0.
- Internal: `state`=0, `cnt`=0, `pressed`=0, `released`=0, `IRQ_EN`=0.
- A reset asserted mid-transaction drops `iomem_ready` immediately. Any pending write is discarded.

Bus handshake:
- On an edge with `iomem_valid`=1 and `iomem_ready`=0, the block performs the write or captures `iomem_rdata`, and sets `iomem_ready`=1.
- On the next edge `iomem_ready` returns to 0, regardless of `iomem_valid`.
- Result: 1 wait state, and `ready` never holds high for 2 cycles.
- Read data reflects register contents before any event set on that same edge.

Latency:
- A raw input change held steady updates `state` exactly `DEBOUNCE_CYCLES + 2` edges after the first edge that samples it.
- `pressed`/`released` are set on the same edge as the `state` change.
- `irq` follows 1 edge later.
- After a W1C clear that empties all enabled events, `irq` falls 1 edge after the `ready` edge.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4.

- Reset check: hold `buttons_n`=`8'hFF`, read `STATE`/`PRESSED`/`RELEASED`/`IRQ_EN` → all `0`; each read's `ready` is high for exactly 1 cycle, 1 cycle after `valid`.
- Debounce of a real press: drive `buttons_n[3]`=0 and hold → `STATE`=`0x08` and `PRESSED`=`0x08` exactly 6 edges later; no change before that.
- Glitch rejection: pulse `buttons_n[0]` low for 3 cycles → `STATE` stays 0 and `PRESSED` stays 0.
- Interrupt and clear: write `IRQ_EN`=`0x0000_0008`, press button 3 → `irq`=1; write `PRESSED`=`0x08` → `irq`=0 one edge after `ready`; `RELEASED` is unaffected.
- Set-wins collision: time a W1C write to `PRESSED` bit 5 to land on the edge where `state[5]` rises → `PRESSED[5]` reads 1.
- Byte strobes: write `IRQ_EN`=`0xFFFF_FFFF` with `wstrb`=`4'b0100` → reads `0x00FF_0000`; async reset asserted mid-transaction → `ready`=0 and `IRQ_EN`=0 immediately.
